// File: rtl/seq_mult_32.sv
// Sequential unsigned WIDTH x WIDTH shift-and-add multiplier, one iteration per clock.
// The partial-sum addition each cycle is done by an embedded 32-bit ripple adder.

module s32_bit_adder (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {32'd0, cin};
endmodule

module seq_mult_32 #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state_q;
  state_t             state_d;
  logic [WIDTH-1:0]   acc;
  logic [WIDTH-1:0]   mreg;
  logic [WIDTH-1:0]   mcand;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   sum;
  logic               cout;
  logic [WIDTH-1:0]   acc_nxt;
  logic [WIDTH-1:0]   mreg_nxt;
  logic               last_iter;

  s32_bit_adder u_add (
    .a    (acc),
    .b    (mcand),
    .cin  (1'b0),
    .sum  (sum),
    .cout (cout)
  );

  // One shift-and-add step; the adder carry becomes the new top bit of acc.
  always_comb begin
    acc_nxt  = {1'b0, acc[WIDTH-1:1]};
    mreg_nxt = {acc[0], mreg[WIDTH-1:1]};
    if (mreg[0]) begin
      acc_nxt  = {cout, sum[WIDTH-1:1]};
      mreg_nxt = {sum[0], mreg[WIDTH-1:1]};
    end
  end

  assign last_iter = (cnt == CNT_W'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: if (start) state_d = CALC;
      CALC: begin
        busy = 1'b1;
        if (last_iter) state_d = DONE;
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      mreg    <= '0;
      mcand   <= '0;
      cnt     <= '0;
      product <= '0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          mcand <= multiplicand;
          mreg  <= multiplier;
          acc   <= '0;
          cnt   <= '0;
        end
        CALC: begin
          acc  <= acc_nxt;
          mreg <= mreg_nxt;
          cnt  <= cnt + CNT_W'(1);
          if (last_iter) product <= {acc_nxt, mreg_nxt};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mult_32.sv
// Directed bench for seq_mult_32: scoreboard queue of expected products,
// cycle-accurate checks of busy/done/product around every operation.

module tb_seq_mult_32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] multiplicand = '0;
  logic [31:0] multiplier = '0;
  logic [63:0] product;
  logic        busy;
  logic        done;

  int          tests = 0;
  int          fails = 0;
  logic [63:0] exp_q[$];
  logic [63:0] last_prod = '0;

  seq_mult_32 dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .product      (product),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drives one start at a negedge, then walks 34 edges counted from the
  // accepting edge (edge 1). Extra starts with A=B=1 are pulsed at p1/p2.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input int p1, input int p2);
    logic [63:0] exp;
    @(negedge clk);
    start        = 1'b1;
    multiplicand = a;
    multiplier   = b;
    exp_q.push_back(64'(a) * 64'(b));
    for (int k = 1; k <= 34; k++) begin
      @(posedge clk);
      #1;
      if (k < 33) begin
        if (k == 1 || k == 32 || k == p1 || k == p2) begin
          chk({tag, " busy"}, 64'(busy), 64'd1);
          chk({tag, " done low"}, 64'(done), 64'd0);
          chk({tag, " product held"}, product, last_prod);
        end else if (busy !== 1'b1 || done !== 1'b0) begin
          chk({tag, " busy/done mid"}, {62'd0, busy, done}, 64'd2);
        end
      end else if (k == 33) begin
        chk({tag, " done at 33"}, 64'(done), 64'd1);
        chk({tag, " busy at 33"}, 64'(busy), 64'd1);
        chk({tag, " queue nonempty"}, 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) begin
          exp = exp_q.pop_front();
          chk({tag, " product"}, product, exp);
          last_prod = exp;
        end
      end else begin
        chk({tag, " done single pulse"}, 64'(done), 64'd0);
        chk({tag, " idle after done"}, 64'(busy), 64'd0);
        chk({tag, " product hold"}, product, last_prod);
      end
      @(negedge clk);
      if (k == p1 || k == p2) begin
        start        = 1'b1;
        multiplicand = 32'd1;
        multiplier   = 32'd1;
      end else begin
        start        = 1'b0;
        multiplicand = $urandom;
        multiplier   = $urandom;
      end
    end
    start = 1'b0;
  endtask

  initial begin
    int done_seen;
    repeat (2) @(posedge clk);
    #1;
    chk("reset product", product, 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("idle without start", 64'(busy), 64'd0);

    run_op("23x12", 32'd23, 32'd12, 0, 0);
    chk("23x12 literal", last_prod, 64'd276);
    run_op("mid", 32'd321937, 32'd1172056, 0, 0);
    chk("mid literal", last_prod, 64'd377328192472);
    run_op("allones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
    chk("allones literal", last_prod, 64'hFFFF_FFFE_0000_0001);
    run_op("zeroA", 32'd0, 32'hDEAD_BEEF, 0, 0);
    run_op("msb", 32'h8000_0000, 32'd2, 0, 0);
    chk("msb literal", last_prod, 64'h1_0000_0000);
    run_op("ignored starts", 32'd415362004, 32'd23907432, 5, 20);
    run_op("ignore at done", 32'd7, 32'd9, 33, 0);

    // Asynchronous reset in the middle of a calculation.
    @(negedge clk);
    start        = 1'b1;
    multiplicand = 32'd128;
    multiplier   = 32'd89031;
    exp_q.push_back(64'd128 * 64'd89031);
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) chk("pre-reset busy", 64'(busy), 64'd1);
      @(negedge clk);
      start = 1'b0;
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("async reset product", product, 64'd0);
    chk("async reset busy", 64'(busy), 64'd0);
    chk("async reset done", 64'(done), 64'd0);
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    last_prod = '0;
    done_seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (done) done_seen++;
      @(negedge clk);
      if (k == 3) rst_n = 1'b1;
    end
    chk("no done after reset", 64'(done_seen), 64'd0);
    chk("idle after reset", 64'(busy), 64'd0);
    run_op("after reset", 32'd128, 32'd89031, 0, 0);
    chk("after reset literal", last_prod, 64'd11395968);
    chk("scoreboard drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
